// File: rtl/lsu_bus_master_pkg.sv
// Shared bus types for the LSU bus master: transfer size/type and the LSU FSM state.
package lsu_bus_master_pkg;

  typedef enum logic [1:0] {
    BYTE     = 2'd0,
    HALFWORD = 2'd1,
    WORD     = 2'd2
  } tsize_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_t;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StResp
  } lsu_state_t;

  // Encoding 2'd3 is not a transfer size the bus understands.
  function automatic logic size_legal(tsize_t size);
    return (size == BYTE) || (size == HALFWORD) || (size == WORD);
  endfunction

endpackage

// File: rtl/master_bus_if.sv
// Simple request/done system bus between an initiator and a memory-side responder.
interface master_bus_if;
  import lsu_bus_master_pkg::*;

  logic        ss;
  logic        bstart;
  logic [31:0] addr;
  logic [31:0] wdata;
  tsize_t      tsize;
  ttype_t      ttype;
  logic        bdone;
  logic [31:0] rdata;

  modport master (
    output ss, bstart, addr, wdata, tsize, ttype,
    input  bdone, rdata
  );

  modport slave (
    input  ss, bstart, addr, wdata, tsize, ttype,
    output bdone, rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational data alignment: store lane placement, access legality and load extension.
module lsu_align
  import lsu_bus_master_pkg::*;
(
  input  tsize_t      st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [31:0] lane_wdata,
  output logic        bad_access,
  input  tsize_t      ld_size,
  input  logic        ld_signed,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  always_comb begin
    lane_wdata = st_data;
    bad_access = !size_legal(st_size);
    case (st_size)
      BYTE:     lane_wdata = {4{st_data[7:0]}};
      HALFWORD: begin
        lane_wdata = {2{st_data[15:0]}};
        bad_access = st_addr_lo[0];
      end
      WORD:     bad_access = |st_addr_lo;
      default:  ;
    endcase
  end

  // Load data arrives right-justified regardless of address.
  always_comb begin
    ld_data = ld_rdata;
    case (ld_size)
      BYTE:     ld_data = {{24{ld_signed & ld_rdata[7]}}, ld_rdata[7:0]};
      HALFWORD: ld_data = {{16{ld_signed & ld_rdata[15]}}, ld_rdata[15:0]};
      default:  ;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// LSU bus master: one outstanding load/store, START/WAIT handshake on master_bus_if.
// Optional WAIT timeout abort enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  master_bus_if.master bus,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_addr,
  input  logic         req_we,
  input  tsize_t       req_size,
  input  logic         req_signed,
  input  logic [31:0]  req_wdata,
  output logic         resp_valid,
  output logic [31:0]  resp_rdata,
  output logic         resp_err
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  tsize_t      size_q;
  logic        we_q, signed_q, err_q;

  logic [31:0] lane_wdata, ld_data;
  logic        bad_access, accept, timeout_hit;
  logic        ss, bstart;

  lsu_align u_align (
    .st_size    (req_size),
    .st_addr_lo (req_addr[1:0]),
    .st_data    (req_wdata),
    .lane_wdata (lane_wdata),
    .bad_access (bad_access),
    .ld_size    (size_q),
    .ld_signed  (signed_q),
    .ld_rdata   (bus.rdata),
    .ld_data    (ld_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [CntW-1:0] cnt_q;

  // Counts completed WAIT cycles; the limit cycle is the TIMEOUT_CYCLES-th one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q != StWait) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  assign accept = (state_q == StIdle) && req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ss         = 1'b0;
    bstart     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = bad_access ? StResp : StStart;
      end
      StStart: begin
        ss      = 1'b1;
        bstart  = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        ss = 1'b1;
        if (bus.bdone || timeout_hit) state_d = StResp;
      end
      StResp: begin
        resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      size_q   <= BYTE;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      addr_q   <= req_addr;
      wdata_q  <= lane_wdata;
      rdata_q  <= '0;
      size_q   <= req_size;
      we_q     <= req_we;
      signed_q <= req_signed;
      err_q    <= bad_access;
    end else if (state_q == StWait) begin
      // bdone on the limit cycle completes normally rather than timing out.
      if (bus.bdone) begin
        rdata_q <= we_q ? 32'h0 : ld_data;
      end else if (timeout_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid & err_q;

  assign bus.ss     = ss;
  assign bus.bstart = bstart;
  assign bus.addr   = addr_q;
  assign bus.wdata  = wdata_q;
  assign bus.tsize  = size_q;
  assign bus.ttype  = we_q ? WRITE : READ;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Randomized + directed bench for lsu_bus_master against a transaction-level model.
module tb_lsu_bus_master;
  import lsu_bus_master_pkg::*;

  localparam int unsigned To = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  tsize_t      req_size = BYTE;
  logic        req_signed = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_tests = 0;
  int n_fail  = 0;

  master_bus_if bus_if ();

  always #5 clk = ~clk;

  lsu_bus_master #(.TIMEOUT_CYCLES(To)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned nbytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_err(input logic [31:0] a, input logic [1:0] sz);
    int unsigned nb = nbytes(sz);
    return (nb == 0) || ((a % nb) != 0);
  endfunction

  function automatic logic [31:0] lane(input logic [31:0] w, input logic [1:0] sz);
    case (nbytes(sz))
      1:       return (w & 32'hFF) * 32'h0101_0101;
      2:       return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] r, input logic [1:0] sz, input bit sgn);
    int unsigned nb = nbytes(sz);
    longint m, v;
    if (nb == 4) return r;
    m = 64'sd1 <<< (8 * nb);
    v = longint'(r) % m;
    if (sgn && v >= m / 2) v = v - m;
    return 32'(v);
  endfunction

  // d = WAIT cycles before the responder raises bdone; noise = spurious bdone in START/RESP.
  task automatic run_access(input logic [31:0] a, input logic we, input logic [1:0] sz,
                            input logic sgn, input logic [31:0] wd, input int d,
                            input logic [31:0] rd, input bit noise);
    bit err, tmo, got;
    int lat, c;
    logic [31:0] exp_rd;
    err = is_err(a, sz);
`ifdef LSU_TIMEOUT_EN
    tmo = !err && (d >= int'(To));
`else
    tmo = 1'b0;
`endif
    if (err)      lat = 1;
    else if (tmo) lat = int'(To) + 2;
    else          lat = d + 3;
    exp_rd = (err || tmo || we) ? 32'h0 : extend(rd, sz, sgn);

    @(negedge clk);
    bus_if.bdone = 1'b0;
    check_eq("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_addr   = a;
    req_we     = we;
    req_size   = tsize_t'(sz);
    req_signed = sgn;
    req_wdata  = wd;
    c   = 0;
    got = 1'b0;
    while (!got && c < lat + 8) begin
      @(negedge clk);
      c++;
      req_valid    = 1'b0;
      req_addr     = $urandom;
      req_wdata    = $urandom;
      bus_if.bdone = 1'b0;
      bus_if.rdata = $urandom;
      check_eq("ss", {31'h0, bus_if.ss}, {31'h0, !err && c < lat});
      check_eq("bstart", {31'h0, bus_if.bstart}, {31'h0, !err && c == 1});
      check_eq("resp_valid", {31'h0, resp_valid}, {31'h0, c == lat});
      check_eq("req_ready_busy", {31'h0, req_ready}, 32'h0);
      if (!err && c < lat) begin
        check_eq("bus_addr", bus_if.addr, a);
        check_eq("bus_wdata", bus_if.wdata, lane(wd, sz));
        check_eq("bus_tsize", {30'h0, bus_if.tsize}, {30'h0, sz});
        check_eq("bus_ttype", {31'h0, bus_if.ttype}, {31'h0, we});
      end
      if (resp_valid) begin
        got = 1'b1;
        check_eq("resp_err", {31'h0, resp_err}, {31'h0, err || tmo});
        check_eq("resp_rdata", resp_rdata, exp_rd);
      end
      if (!err && !tmo && c == 2 + d) begin
        bus_if.bdone = 1'b1;
        bus_if.rdata = rd;
      end else if (noise && (c == 1 || c == lat)) begin
        bus_if.bdone = 1'b1;
      end
    end
    check_eq("resp_seen", {31'h0, got}, 32'h1);
    check_eq("latency", c, lat);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ss"}, {31'h0, bus_if.ss}, 32'h0);
    check_eq({tag, "_bstart"}, {31'h0, bus_if.bstart}, 32'h0);
    check_eq({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h0);
    check_eq({tag, "_resp_err"}, {31'h0, resp_err}, 32'h0);
    check_eq({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    check_eq({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    check_eq({tag, "_addr"}, bus_if.addr, 32'h0);
    check_eq({tag, "_wdata"}, bus_if.wdata, 32'h0);
    check_eq({tag, "_tsize"}, {30'h0, bus_if.tsize}, 32'h0);
    check_eq({tag, "_ttype"}, {31'h0, bus_if.ttype}, 32'h0);
  endtask

  initial begin
    bit seen_resp;
    bus_if.bdone = 1'b0;
    bus_if.rdata = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;

    run_access(32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    run_access(32'h103, 1'b0, 2'd0, 1'b1, 32'h0, 0, 32'h0000_0080, 1'b0);
    run_access(32'h103, 1'b0, 2'd0, 1'b0, 32'h0, 0, 32'h0000_0080, 1'b0);
    run_access(32'h102, 1'b1, 2'd1, 1'b0, 32'h1234_ABCD, 2, 32'h5555_AAAA, 1'b1);
    run_access(32'h101, 1'b0, 2'd2, 1'b0, 32'h0, 0, 32'h1111_1111, 1'b0);
    run_access(32'h202, 1'b0, 2'd1, 1'b1, 32'h0, 1, 32'h0000_8001, 1'b1);
    run_access(32'h200, 1'b0, 2'd3, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    run_access(32'h300, 1'b0, 2'd2, 1'b0, 32'h0, 10, 32'hCAFE_F00D, 1'b0);
    run_access(32'h304, 1'b0, 2'd2, 1'b0, 32'h0, int'(To) - 1, 32'hCAFE_F00D, 1'b0);

    for (int i = 0; i < 80; i++) begin
      run_access($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 5)), $urandom,
                 1'($urandom_range(0, 1)));
    end

    // Abort a transaction mid-WAIT; a late bdone must not produce a response.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h400;
    req_we    = 1'b0;
    req_size  = WORD;
    @(negedge clk);
    req_valid = 1'b0;
    seen_resp = 1'b0;
`ifdef LSU_TIMEOUT_EN
    repeat (2) @(negedge clk);
`else
    repeat (1000) begin
      @(negedge clk);
      if (resp_valid) seen_resp = 1'b1;
    end
`endif
    check_eq("long_wait_ss", {31'h0, bus_if.ss}, 32'h1);
    check_eq("long_wait_no_resp", {31'h0, seen_resp}, 32'h0);
    rst_n = 1'b0;
    #1;
    check_quiet("midreset");
    @(negedge clk);
    rst_n        = 1'b1;
    bus_if.bdone = 1'b1;
    bus_if.rdata = 32'h1234_5678;
    @(negedge clk);
    bus_if.bdone = 1'b0;
    repeat (4) begin
      check_quiet("after_reset");
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_bus_master.md
LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, bus-wait cycles before abort (used only when LSU_TIMEOUT_EN is defined).
REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bus  master_bus_if.master  -  drives ss, bstart, addr[31:0], wdata[31:0], tsize, ttype; samples bdone, rdata[31:0].
- req_valid  input  1  core requests an access.
- req_ready  output  1  block accepts a request this cycle.
- req_addr  input  32  byte address.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  tsize_t  WORD / HALFWORD / BYTE.
- req_signed  input  1  sign-extend load result.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned, illegal size or timeout.

Function
REQ-003 SHALL implement FSM IDLE, START, WAIT, RESP; req_ready = (state == IDLE).
REQ-004 SHALL in IDLE, on req_valid, register addr, size, we, signed and lane-placed wdata.
REQ-005 SHALL route accepted requests from IDLE: to RESP with resp_err=1 and no bus activity if misaligned (WORD with addr[1:0]!=0, HALFWORD with addr[0]=1) or size illegal; otherwise to START.
REQ-006 SHALL in START drive ss=1 and bstart=1 for exactly one cycle, then go to WAIT.
REQ-007 SHALL in WAIT hold ss=1 and bstart=0, and ignore bdone in START.
REQ-008 SHALL on bdone in WAIT capture rdata and go to RESP.
REQ-009 SHALL hold addr, tsize, ttype and wdata stable from START through the bdone cycle.
REQ-010 SHALL in RESP assert resp_valid for one cycle with ss=0, then return to IDLE.
REQ-011 SHALL use 3 cycles from acceptance to resp_valid against a one-cycle-bdone responder, and 1 cycle for a misalignment error.
REQ-012 SHALL drive ttype=WRITE when we=1, else READ; tsize equals the registered size.
REQ-013 SHALL place store data in lanes: BYTE replicated to all four bytes, HALFWORD replicated to both halves, WORD unchanged.
REQ-014 SHALL treat load rdata as right-justified and extend it: BYTE uses bit 7, HALFWORD uses bit 15, sign-extended if signed else zero-extended; WORD passes through.
REQ-015 SHALL ignore bdone in IDLE and RESP, with no state change.
REQ-016 SHALL not accept back-to-back requests: the earliest next acceptance is the cycle after RESP.

Reset
REQ-017 SHALL on rst_n low, at any time including mid-transaction: state=IDLE, ss=0, bstart=0, resp_valid=0, resp_err=0, resp_rdata=0, all registered fields 0, timeout counter 0.
REQ-018 SHALL not complete an aborted transaction or emit a response for it after reset.

Configuration
REQ-019 SHALL, with LSU_TIMEOUT_EN defined: count WAIT cycles from 0; if the count reaches TIMEOUT_CYCLES without bdone, go to RESP with resp_err=1, resp_rdata=0, ss=0; a bdone in the same cycle as the limit wins.
REQ-020 SHALL, without LSU_TIMEOUT_EN: contain no counter and wait indefinitely in WAIT.

Structure
REQ-021 SHALL take tsize_t (WORD, HALFWORD, BYTE) and ttype_t (READ, WRITE) from the existing shared bus package, and add lsu_state_t there.
REQ-022 SHALL place lane placement, misalignment check and load extension in a combinational sub-module lsu_align; the FSM, registers and timeout stay in lsu_bus_master.

Verification
REQ-023 SHALL cover these directed scenarios:
- Load WORD addr 0x100, rdata 0xDEADBEEF, bdone one cycle after bstart -> resp_valid at cycle 3, resp_rdata 0xDEADBEEF, resp_err=0.
- Load BYTE signed addr 0x103, rdata 0x00000080 -> resp_rdata 0xFFFFFF80; unsigned -> 0x00000080.
- Store HALFWORD addr 0x102, req_wdata 0x1234ABCD -> bus wdata 0xABCDABCD, ttype WRITE, tsize HALFWORD, ss high START through bdone.
- Load WORD addr 0x101 -> resp_err=1 one cycle after acceptance, ss and bstart never asserted.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no bdone -> resp_err=1 after 4 WAIT cycles, ss drops; without macro, still waiting at 1000 cycles.
- rst_n low during WAIT, then bdone after release -> no resp_valid, req_ready=1, all outputs 0.
